// File: rtl/rx_correlation_scheduler_pkg.sv
// Shared rx constants: default correlator geometry and the scheduler FSM encoding.
package rx_correlation_scheduler_pkg;

  localparam int unsigned RX_SEQ_COUNT  = 16;
  localparam int unsigned RX_CORR_WIDTH = 41;
  localparam int unsigned RX_IDX_W      = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;
  localparam logic [1:0] ST_REPORT = 2'd3;

endpackage

// File: rtl/rx_correlation_scheduler_peak_tracker.sv
// Running maximum of |sample| with its index; the lowest index wins ties.
module rx_peak_tracker #(
  parameter int unsigned W     = 41,
  parameter int unsigned IDX_W = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  input  logic                    first_i,
  input  logic [IDX_W-1:0]        idx_i,
  input  logic signed [W-1:0]     sample_i,
  output logic [W-1:0]            max_nxt_o,
  output logic [IDX_W-1:0]        idx_nxt_o
);

  localparam logic [W-1:0] MAG_SAT = {1'b0, {(W-1){1'b1}}};

  logic [W-1:0]     mag;
  logic [W-1:0]     max_q;
  logic [W-1:0]     base_max;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] base_idx;

  // The most-negative value has no positive twin, so it clamps to the largest magnitude.
  always_comb begin
    mag = $unsigned(sample_i);
    if (sample_i[W-1]) begin
      if (sample_i[W-2:0] == '0) mag = MAG_SAT;
      else                       mag = $unsigned(-sample_i);
    end
  end

  always_comb begin
    base_max  = first_i ? '0 : max_q;
    base_idx  = first_i ? '0 : idx_q;
    max_nxt_o = base_max;
    idx_nxt_o = base_idx;
    if (mag > base_max) begin
      max_nxt_o = mag;
      idx_nxt_o = idx_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      max_q <= '0;
      idx_q <= '0;
    end else if (valid_i) begin
      max_q <= max_nxt_o;
      idx_q <= idx_nxt_o;
    end
  end

endmodule

// File: rtl/rx_correlation_scheduler.sv
// Window scheduler: counts bit-ready pulses, scans the correlation bus for the
// strongest sequence and reports it when it clears the threshold.
module rx_correlation_scheduler
  import rx_correlation_scheduler_pkg::*;
#(
  parameter int unsigned BITS_PER_WINDOW = 511,
  parameter int unsigned SEQ_COUNT       = RX_SEQ_COUNT,
  parameter int unsigned CORR_WIDTH      = RX_CORR_WIDTH
) (
  input  logic                            crx_clk,
  input  logic                            rrx_rst,
  input  logic                            erx_en,
  input  logic                            ibit_ready,
  input  logic [SEQ_COUNT*CORR_WIDTH-1:0] icorrelation_bus,
  input  logic [CORR_WIDTH-1:0]           ithreshold,
  input  logic                            iack,
  output logic                            oclear,
  output logic                            obusy,
  output logic                            odetect_valid,
  output logic [3:0]                      odetect_id,
  output logic [CORR_WIDTH-1:0]           odetect_peak
);

  localparam logic [15:0]         BPW      = 16'(BITS_PER_WINDOW);
  localparam logic [RX_IDX_W-1:0] LAST_IDX = RX_IDX_W'(SEQ_COUNT - 1);

  logic [1:0]                  state_q, state_d;
  logic [15:0]                 cnt_q, cnt_d;
  logic [RX_IDX_W-1:0]         scan_idx_q, scan_idx_d;
  logic [CORR_WIDTH-1:0]       thr_q, thr_d;
  logic                        clear_q, clear_d;
  logic [RX_IDX_W-1:0]         id_q, id_d;
  logic [CORR_WIDTH-1:0]       peak_q, peak_d;
  logic signed [CORR_WIDTH-1:0] cur_sample;
  logic [CORR_WIDTH-1:0]       trk_max;
  logic [RX_IDX_W-1:0]         trk_idx;

  assign cur_sample = icorrelation_bus[int'(scan_idx_q)*CORR_WIDTH +: CORR_WIDTH];

  rx_peak_tracker #(
    .W     (CORR_WIDTH),
    .IDX_W (RX_IDX_W)
  ) u_peak (
    .clk_i     (crx_clk),
    .rst_i     (rrx_rst),
    .valid_i   (state_q == ST_SCAN),
    .first_i   (scan_idx_q == '0),
    .idx_i     (scan_idx_q),
    .sample_i  (cur_sample),
    .max_nxt_o (trk_max),
    .idx_nxt_o (trk_idx)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    scan_idx_d = scan_idx_q;
    thr_d      = thr_q;
    id_d       = id_q;
    peak_d     = peak_q;
    clear_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d      = '0;
        scan_idx_d = '0;
        if (erx_en) begin
          state_d = ST_ACCUM;
          clear_d = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (ibit_ready) begin
          cnt_d = cnt_q + 16'd1;
          if ((cnt_q + 16'd1) == BPW) begin
            state_d    = ST_SCAN;
            scan_idx_d = '0;
            thr_d      = ithreshold;
          end
        end
      end
      ST_SCAN: begin
        scan_idx_d = scan_idx_q + 1'b1;
        // The final candidate is folded in combinationally so the verdict costs no extra cycle.
        if (scan_idx_q == LAST_IDX) begin
          scan_idx_d = '0;
          if (trk_max > thr_q) begin
            state_d = ST_REPORT;
            id_d    = trk_idx;
            peak_d  = trk_max;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_REPORT: begin
        if (iack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!erx_en) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      scan_idx_d = '0;
      clear_d    = 1'b0;
    end
    if (state_d != ST_REPORT) begin
      id_d   = '0;
      peak_d = '0;
    end
  end

  always_ff @(posedge crx_clk) begin
    if (rrx_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      scan_idx_q <= '0;
      thr_q      <= '0;
      clear_q    <= 1'b0;
      id_q       <= '0;
      peak_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      scan_idx_q <= scan_idx_d;
      thr_q      <= thr_d;
      clear_q    <= clear_d;
      id_q       <= id_d;
      peak_q     <= peak_d;
    end
  end

  assign oclear        = clear_q;
  assign obusy         = (state_q == ST_ACCUM) || (state_q == ST_SCAN);
  assign odetect_valid = (state_q == ST_REPORT);
  assign odetect_id    = 4'(id_q);
  assign odetect_peak  = peak_q;

endmodule

// File: doc/rx_correlation_scheduler.md
RX_CORRELATION_SCHEDULER -- requirements
Module: rx_correlation_scheduler

Interface
REQ-001 Parameter BITS_PER_WINDOW, default 511: number of bit-ready pulses accumulated per correlation window (range 2..65535).
REQ-002 Parameter SEQ_COUNT, default 16: number of binary sequences correlated in parallel.
REQ-003 Parameter CORR_WIDTH, default 41: signed width of each correlation value.
REQ-004 crx_clk  in  1  single clock; all logic rising-edge.
REQ-005 rrx_rst  in  1  synchronous reset, active-high.
REQ-006 erx_en  in  1  enable; low = block held in IDLE, outputs at reset values.
REQ-007 ibit_ready  in  1  one-cycle pulse from the correlation datapath, one per accumulated bit.
REQ-008 icorrelation_bus  in  SEQ_COUNT*CORR_WIDTH  signed correlation values; sequence k occupies bits [k*CORR_WIDTH +: CORR_WIDTH].
REQ-009 ithreshold  in  CORR_WIDTH  unsigned detection threshold on peak magnitude, sampled at SCAN entry.
REQ-010 iack  in  1  consumer acknowledge of a detection.
REQ-011 oclear  out  1  one-cycle pulse that clears the datapath accumulators.
REQ-012 obusy  out  1  high in ACCUM and SCAN.
REQ-013 odetect_valid  out  1  detection available.
REQ-014 odetect_id  out  4  index of winning sequence.
REQ-015 odetect_peak  out  CORR_WIDTH  magnitude of winning correlation.

Function
REQ-016 FSM states IDLE, ACCUM, SCAN, REPORT.
REQ-017 IDLE -> ACCUM when erx_en high; oclear asserted for exactly the IDLE->ACCUM transition cycle; bit counter set to 0.
REQ-018 ACCUM: counter increments on each ibit_ready; on the pulse making count = BITS_PER_WINDOW, next state SCAN.
REQ-019 SCAN: one sequence per cycle, index 0 to SEQ_COUNT-1, exactly SEQ_COUNT cycles; icorrelation_bus must be stable (no ibit_ready expected); ibit_ready during SCAN is ignored.
REQ-020 Magnitude = absolute value; most-negative input saturates to 2^(CORR_WIDTH-1)-1.
REQ-021 Strictly-greater comparison; ties keep the lower index.
REQ-022 After last scan cycle: if peak > latched threshold -> REPORT, else -> IDLE (new window starts next cycle with oclear).
REQ-023 REPORT: odetect_valid high, odetect_id/odetect_peak stable until iack sampled high; then odetect_valid low next cycle, state IDLE.
REQ-024 iack outside REPORT ignored; iack high on REPORT entry cycle is honoured on the following cycle (valid visible at least one cycle).
REQ-025 erx_en low in any state: next cycle state IDLE, counter 0, odetect_valid 0, pending detection discarded.
REQ-026 Detection latency: odetect_valid rises SEQ_COUNT+1 cycles after the final ibit_ready of a window.

Reset
REQ-027 rrx_rst high: state IDLE, counter 0, oclear 0, obusy 0, odetect_valid 0, odetect_id 0, odetect_peak 0, scan max/index 0.
REQ-028 Reset mid-ACCUM/SCAN/REPORT has the same effect as REQ-027 with no partial detection emitted; rrx_rst dominates erx_en.

Structure
REQ-029 Shared rx package holds the FSM state encoding, SEQ_COUNT and CORR_WIDTH constants, reused by the correlator.
REQ-030 One sub-module rx_peak_tracker: running |x| max with index, saturation per REQ-020, tie rule per REQ-021.
REQ-031 Sized for 120-400 lines of RTL total.

Verification
REQ-032 BITS_PER_WINDOW=4, seq 5 = +1000, others ±10, threshold 500 -> odetect_id=5, odetect_peak=1000, valid 17 cycles after 4th ibit_ready.
REQ-033 seq 3 = -2000, seq 9 = +2000 -> odetect_id=3 (tie, lower index), peak 2000.
REQ-034 All values 100, threshold 100 -> no odetect_valid; oclear pulses again one cycle after scan ends.
REQ-035 seq 0 = -2^40 -> peak = 2^40-1, id 0.
REQ-036 Hold iack low 50 cycles in REPORT -> valid/id/peak stable; iack pulse -> valid low next cycle, oclear the cycle after.
REQ-037 rrx_rst pulse during SCAN cycle 7, then erx_en low mid-ACCUM -> all outputs 0, no valid, fresh oclear on restart.
